// File: rtl/int_ctrl_n_if.sv
// Decoder-facing handshake of the interrupt controller: global-enable controls,
// request/acknowledge, return-from-interrupt and the committed vector.
interface int_ctrl_n_if #(
    parameter int N_SRC = 4,
    parameter int VEC_W = 8
);
    localparam int ID_W = $clog2(N_SRC);

    logic             int_enable;
    logic             int_disable;
    logic             reti;
    logic             irq_ack;
    logic             irq;
    logic [VEC_W-1:0] irq_vector;
    logic [ID_W-1:0]  active_id;
    logic             in_service;
    logic             gie;

    modport master (
        input  int_enable, int_disable, reti, irq_ack,
        output irq, irq_vector, active_id, in_service, gie
    );

    modport slave (
        output int_enable, int_disable, reti, irq_ack,
        input  irq, irq_vector, active_id, in_service, gie
    );
endinterface

// File: rtl/int_ctrl_n.sv
// Fixed-priority interrupt controller: per-source mask and edge/level capture,
// one committed request at a time, in-service tracking until reti.
module int_ctrl_n #(
    parameter int              N_SRC      = 4,
    parameter int              VEC_W      = 8,
    parameter logic [VEC_W-1:0] VEC_BASE  = VEC_W'(2),
    parameter int              VEC_STRIDE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             mode_we,
    input  logic [N_SRC-1:0] mode_wdata,
    output logic [N_SRC-1:0] pending,
    int_ctrl_n_if.master     bus
);
    localparam int ID_W = $clog2(N_SRC);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t           state_q, state_d;
    logic             irq_q, irq_d;
    logic             in_service_q, in_service_d;
    logic             gie_q, gie_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] mode_q, mode_d;
    logic [N_SRC-1:0] src_prev_q;
    logic [ID_W-1:0]  first_id;

    function automatic logic [VEC_W-1:0] vector_of(input logic [ID_W-1:0] idx);
        return VEC_W'(int'(VEC_BASE) + int'(idx) * VEC_STRIDE);
    endfunction

    always_comb begin
        state_d      = state_q;
        irq_d        = irq_q;
        in_service_d = in_service_q;
        vec_d        = vec_q;
        id_d         = id_q;
        mask_d       = mask_q;
        mode_d       = mode_q;
        first_id     = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pending_q[i]) first_id = ID_W'(i);
        end

        // Capture runs regardless of gie so requests raised under CLI survive.
        for (int i = 0; i < N_SRC; i++) begin
            pending_d[i] = mode_q[i] ? (pending_q[i] | (src[i] & ~src_prev_q[i] & mask_q[i]))
                                     : (src[i] & mask_q[i]);
        end

        gie_d = gie_q;
        if (bus.int_disable)                gie_d = 1'b0;
        else if (bus.int_enable || bus.reti) gie_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (gie_q && (|pending_q)) begin
                    state_d = REQ;
                    irq_d   = 1'b1;
                    id_d    = first_id;
                    vec_d   = vector_of(first_id);
                end
            end
            REQ: begin
                if (bus.irq_ack) begin
                    state_d      = SERVICE;
                    irq_d        = 1'b0;
                    vec_d        = '0;
                    in_service_d = 1'b1;
                    gie_d        = 1'b0;
                    if (mode_q[id_q]) pending_d[id_q] = 1'b0;
                end else if (bus.int_disable) begin
                    state_d = IDLE;
                    irq_d   = 1'b0;
                    vec_d   = '0;
                end
            end
            SERVICE: begin
                if (bus.reti) begin
                    state_d      = IDLE;
                    in_service_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A source switching capture mode starts over with nothing pending.
        if (mode_we) begin
            pending_d = pending_d & ~(mode_q ^ mode_wdata);
            mode_d    = mode_wdata;
        end
        if (mask_we) begin
            pending_d = pending_d & mask_wdata;
            mask_d    = mask_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            irq_q        <= 1'b0;
            in_service_q <= 1'b0;
            gie_q        <= 1'b0;
            vec_q        <= '0;
            id_q         <= '0;
            pending_q    <= '0;
            mask_q       <= '0;
            mode_q       <= '1;
            src_prev_q   <= '0;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_d;
            in_service_q <= in_service_d;
            gie_q        <= gie_d;
            vec_q        <= vec_d;
            id_q         <= id_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            mode_q       <= mode_d;
            src_prev_q   <= src;
        end
    end

    assign bus.irq        = irq_q;
    assign bus.irq_vector = vec_q;
    assign bus.active_id  = id_q;
    assign bus.in_service = in_service_q;
    assign bus.gie        = gie_q;
    assign pending        = pending_q;
endmodule

// File: tb/tb_int_ctrl_n.sv
// Bench for int_ctrl_n: directed scenarios with fixed expectations, then a
// randomized run against a cycle-level reference model of the controller rules.
module tb_int_ctrl_n;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] src = '0;
    logic       mask_we = 1'b0;
    logic [3:0] mask_wdata = '0;
    logic       mode_we = 1'b0;
    logic [3:0] mode_wdata = '0;
    logic [3:0] pending;

    int tests_run = 0;
    int tests_failed = 0;

    int_ctrl_n_if #(.N_SRC(4), .VEC_W(8)) bus ();

    int_ctrl_n #(.N_SRC(4), .VEC_W(8), .VEC_BASE(8'h02), .VEC_STRIDE(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .src        (src),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mode_we    (mode_we),
        .mode_wdata (mode_wdata),
        .pending    (pending),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Reference model: who is requesting/being served, plus captured state.
    bit       m_gie, m_req, m_serv;
    int       m_id;
    bit [3:0] m_pend, m_mask, m_mode, m_prev;

    function automatic void model_step();
        bit [3:0] p;
        bit ngie, nreq, nserv, took;
        int nid;
        if (rst) begin
            m_gie = 0; m_req = 0; m_serv = 0; m_id = 0;
            m_pend = 0; m_mask = 0; m_mode = 4'hF; m_prev = 0;
            return;
        end
        ngie = m_gie;
        if (bus.int_enable || bus.reti) ngie = 1;
        if (bus.int_disable) ngie = 0;
        nreq = m_req; nserv = m_serv; nid = m_id; took = 0;
        if (m_serv) begin
            if (bus.reti) nserv = 0;
        end else if (m_req) begin
            if (bus.irq_ack) begin
                nreq = 0; nserv = 1; ngie = 0; took = 1;
            end else if (bus.int_disable) begin
                nreq = 0;
            end
        end else if (m_gie && m_pend != 0) begin
            nreq = 1;
            for (int i = 3; i >= 0; i--) if (m_pend[i]) nid = i;
        end
        for (int i = 0; i < 4; i++) begin
            if (m_mode[i]) p[i] = m_pend[i] || (src[i] && !m_prev[i] && m_mask[i]);
            else           p[i] = src[i] && m_mask[i];
            if (took && i == m_id && m_mode[i]) p[i] = 0;
            if (mode_we && mode_wdata[i] != m_mode[i]) p[i] = 0;
            if (mask_we && !mask_wdata[i]) p[i] = 0;
        end
        m_pend = p;
        m_prev = src;
        if (mask_we) m_mask = mask_wdata;
        if (mode_we) m_mode = mode_wdata;
        m_gie = ngie; m_req = nreq; m_serv = nserv; m_id = nid;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        src = '0; mask_we = 0; mode_we = 0;
        bus.int_enable = 0; bus.int_disable = 0; bus.reti = 0; bus.irq_ack = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; tick(); tick();
        tests_run++;
        if (bus.irq !== 1'b0 || bus.irq_vector !== 8'h00 || bus.active_id !== 2'd0 ||
            bus.in_service !== 1'b0 || pending !== 4'h0 || bus.gie !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset: irq=%b vec=%h id=%0d insvc=%b pend=%b gie=%b, required all zero",
                     bus.irq, bus.irq_vector, bus.active_id, bus.in_service, pending, bus.gie);
        end
        rst = 0;
    endtask

    task automatic test_basic_edge();
        mask_we = 1; mask_wdata = 4'b1111; bus.int_enable = 1; tick();
        mask_we = 0; bus.int_enable = 0;
        src = 4'b0100; tick(); src = 0;
        tests_run++;
        if (pending !== 4'b0100 || bus.irq !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL edge_capture: pend=%b irq=%b, required 0100 0", pending, bus.irq);
        end
        tick();
        tests_run++;
        if (bus.irq !== 1'b1 || bus.irq_vector !== 8'h06 || bus.active_id !== 2'd2) begin
            tests_failed++;
            $display("[TB] FAIL edge_req: irq=%b vec=%h id=%0d, required 1 06 2",
                     bus.irq, bus.irq_vector, bus.active_id);
        end
        bus.irq_ack = 1; tick(); bus.irq_ack = 0;
        tests_run++;
        if (pending !== 4'b0000 || bus.in_service !== 1'b1 || bus.gie !== 1'b0 ||
            bus.irq !== 1'b0 || bus.irq_vector !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL edge_ack: pend=%b insvc=%b gie=%b irq=%b vec=%h, required 0000 1 0 0 00",
                     pending, bus.in_service, bus.gie, bus.irq, bus.irq_vector);
        end
        bus.reti = 1; tick(); bus.reti = 0;
        tests_run++;
        if (bus.in_service !== 1'b0 || bus.gie !== 1'b1 || bus.active_id !== 2'd2) begin
            tests_failed++;
            $display("[TB] FAIL edge_reti: insvc=%b gie=%b id=%0d, required 0 1 2",
                     bus.in_service, bus.gie, bus.active_id);
        end
    endtask

    task automatic test_priority();
        src = 4'b1010; tick(); src = 0; tick();
        tests_run++;
        if (bus.irq !== 1'b1 || bus.irq_vector !== 8'h04 || bus.active_id !== 2'd1) begin
            tests_failed++;
            $display("[TB] FAIL prio_first: irq=%b vec=%h id=%0d, required 1 04 1",
                     bus.irq, bus.irq_vector, bus.active_id);
        end
        bus.irq_ack = 1; tick(); bus.irq_ack = 0;
        tests_run++;
        if (pending !== 4'b1000) begin
            tests_failed++;
            $display("[TB] FAIL prio_pend: pend=%b, required 1000", pending);
        end
        bus.reti = 1; tick(); bus.reti = 0;
        tests_run++;
        if (bus.irq !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL prio_gap: irq=%b, required 0", bus.irq);
        end
        tick();
        tests_run++;
        if (bus.irq !== 1'b1 || bus.irq_vector !== 8'h08 || bus.active_id !== 2'd3) begin
            tests_failed++;
            $display("[TB] FAIL prio_second: irq=%b vec=%h id=%0d, required 1 08 3",
                     bus.irq, bus.irq_vector, bus.active_id);
        end
        bus.irq_ack = 1; tick(); bus.irq_ack = 0;
        bus.reti = 1; tick(); bus.reti = 0;
    endtask

    task automatic test_gie_off();
        bus.int_disable = 1; tick(); bus.int_disable = 0;
        src = 4'b0001; tick(); src = 0; tick(); tick();
        tests_run++;
        if (bus.irq !== 1'b0 || pending !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL cli_hold: irq=%b pend=%b, required 0 0001", bus.irq, pending);
        end
        bus.int_enable = 1; tick(); bus.int_enable = 0;
        tests_run++;
        if (bus.irq !== 1'b0 || bus.gie !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL sei_early: irq=%b gie=%b, required 0 1", bus.irq, bus.gie);
        end
        tick();
        tests_run++;
        if (bus.irq !== 1'b1 || bus.irq_vector !== 8'h02 || bus.active_id !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL sei_req: irq=%b vec=%h id=%0d, required 1 02 0",
                     bus.irq, bus.irq_vector, bus.active_id);
        end
        bus.irq_ack = 1; tick(); bus.irq_ack = 0;
        bus.reti = 1; tick(); bus.reti = 0;
    endtask

    task automatic test_level();
        mode_we = 1; mode_wdata = 4'b1101; tick(); mode_we = 0;
        src = 4'b0010; tick();
        tests_run++;
        if (pending !== 4'b0010 || bus.irq !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL level_capture: pend=%b irq=%b, required 0010 0", pending, bus.irq);
        end
        tick();
        bus.irq_ack = 1; tick(); bus.irq_ack = 0;
        tests_run++;
        if (pending !== 4'b0010 || bus.in_service !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL level_ack: pend=%b insvc=%b, required 0010 1", pending, bus.in_service);
        end
        bus.reti = 1; tick(); bus.reti = 0; tick();
        tests_run++;
        if (bus.irq !== 1'b1 || bus.irq_vector !== 8'h04) begin
            tests_failed++;
            $display("[TB] FAIL level_rereq: irq=%b vec=%h, required 1 04", bus.irq, bus.irq_vector);
        end
        src = 0; bus.irq_ack = 1; tick(); bus.irq_ack = 0;
        bus.reti = 1; tick(); bus.reti = 0; tick();
        tests_run++;
        if (bus.irq !== 1'b0 || pending !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL level_cleared: irq=%b pend=%b, required 0 0000", bus.irq, pending);
        end
        mode_we = 1; mode_wdata = 4'b1111; tick(); mode_we = 0;
    endtask

    task automatic test_withdraw();
        src = 4'b0100; tick(); src = 0; tick();
        bus.int_disable = 1; tick(); bus.int_disable = 0;
        tests_run++;
        if (bus.irq !== 1'b0 || pending !== 4'b0100 || bus.gie !== 1'b0 || bus.irq_vector !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL withdraw: irq=%b pend=%b gie=%b vec=%h, required 0 0100 0 00",
                     bus.irq, pending, bus.gie, bus.irq_vector);
        end
        bus.int_enable = 1; tick(); bus.int_enable = 0; tick();
        tests_run++;
        if (bus.irq !== 1'b1 || bus.irq_vector !== 8'h06) begin
            tests_failed++;
            $display("[TB] FAIL withdraw_rereq: irq=%b vec=%h, required 1 06", bus.irq, bus.irq_vector);
        end
        bus.irq_ack = 1; tick(); bus.irq_ack = 0;
        bus.reti = 1; tick(); bus.reti = 0;
        bus.int_enable = 1; bus.int_disable = 1; tick();
        bus.int_enable = 0; bus.int_disable = 0;
        tests_run++;
        if (bus.gie !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL cli_wins: gie=%b, required 0", bus.gie);
        end
        bus.int_enable = 1; tick(); bus.int_enable = 0;
    endtask

    task automatic test_reset_in_service();
        src = 4'b0011; tick(); src = 0; tick();
        bus.irq_ack = 1; src = 4'b1000; tick(); bus.irq_ack = 0; src = 0;
        tests_run++;
        if (bus.in_service !== 1'b1 || pending !== 4'b1010) begin
            tests_failed++;
            $display("[TB] FAIL svc_setup: insvc=%b pend=%b, required 1 1010", bus.in_service, pending);
        end
        rst = 1; tick(); rst = 0;
        tests_run++;
        if (bus.irq !== 1'b0 || bus.irq_vector !== 8'h00 || bus.active_id !== 2'd0 ||
            bus.in_service !== 1'b0 || pending !== 4'h0 || bus.gie !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL svc_reset: irq=%b vec=%h id=%0d insvc=%b pend=%b gie=%b, required all zero",
                     bus.irq, bus.irq_vector, bus.active_id, bus.in_service, pending, bus.gie);
        end
        src = 4'b0001; tick(); src = 0; tick();
        tests_run++;
        if (pending !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_mask: pend=%b, required 0000", pending);
        end
        mask_we = 1; mask_wdata = 4'b1111; tick(); mask_we = 0;
        src = 4'b0010; tick(); tick(); src = 0; tick();
        tests_run++;
        if (pending !== 4'b0010 || bus.irq !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mode: pend=%b irq=%b, required 0010 0", pending, bus.irq);
        end
    endtask

    task automatic test_random();
        int shown = 0;
        logic [7:0] exp_vec;
        clear_inputs();
        rst = 1; tick(); rst = 0;
        for (int c = 0; c < 800; c++) begin
            src            = 4'($urandom) & 4'($urandom);
            mask_we        = ($urandom_range(0, 15) == 0);
            mask_wdata     = 4'($urandom) | 4'($urandom);
            mode_we        = ($urandom_range(0, 24) == 0);
            mode_wdata     = 4'($urandom) | 4'($urandom);
            bus.int_enable  = ($urandom_range(0, 3) == 0);
            bus.int_disable = ($urandom_range(0, 11) == 0);
            bus.irq_ack    = m_req  ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
            bus.reti       = m_serv ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            tick();
            exp_vec = m_req ? 8'(2 + 2 * m_id) : 8'h00;
            tests_run++;
            if (bus.irq !== m_req || bus.irq_vector !== exp_vec || bus.active_id !== 2'(m_id) ||
                bus.in_service !== m_serv || pending !== m_pend || bus.gie !== m_gie) begin
                tests_failed++;
                if (shown < 10) begin
                    shown++;
                    $display("[TB] FAIL random[%0d]: irq=%b vec=%h id=%0d insvc=%b pend=%b gie=%b, required %b %h %0d %b %b %b",
                             c, bus.irq, bus.irq_vector, bus.active_id, bus.in_service, pending, bus.gie,
                             m_req, exp_vec, m_id, m_serv, m_pend, m_gie);
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_basic_edge();
        test_priority();
        test_gie_off();
        test_level();
        test_withdraw();
        test_reset_in_service();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/int_ctrl_n.md
# int_ctrl_n

Parametrised interrupt controller: N_SRC sources, per-source mask and edge/level mode, fixed priority, request/acknowledge handshake to the instruction decoder, and in-service tracking until return from interrupt. Sits between interrupt sources (buttons, timers, peripherals) and ID; ID redirects PC to `irq_vector` on acknowledge.

## Interface
- N_SRC, 4, number of interrupt sources (2..16); index 0 is highest priority
- VEC_W, 8, vector width
- VEC_BASE, 8'h02, vector of source 0
- VEC_STRIDE, 2, vector spacing; vector(i) = VEC_BASE + i*VEC_STRIDE, truncated to VEC_W
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- int_enable  in  1  SEI: set global enable (gie)
- int_disable  in  1  CLI: clear gie
- reti  in  1  return from interrupt: ends service, sets gie
- src  in  N_SRC  raw interrupt inputs, already synchronous to clk
- mask_we  in  1  load `mask` from mask_wdata
- mask_wdata  in  N_SRC  1 = source enabled
- mode_we  in  1  load `mode` from mode_wdata
- mode_wdata  in  N_SRC  1 = rising-edge, 0 = level-high
- irq_ack  in  1  ID has taken the request this cycle
- irq  out  1  request to ID, held until ack or withdrawal
- irq_vector  out  VEC_W  vector of the requested source, stable while irq=1
- active_id  out  clog2(N_SRC)  index of requested/in-service source
- in_service  out  1  handler running (between ack and reti)
- pending  out  N_SRC  registered pending bits
- gie  out  1  global enable

## Operation
- Reset: gie=0, irq=0, irq_vector=0, active_id=0, in_service=0, pending=0, mask=0, mode=all 1 (edge), src_prev=0, state IDLE.
- src_prev <= src every cycle. Edge source i: pending[i] set at clock where src[i]=1, src_prev[i]=0, mask[i]=1. Stays set until cleared by ack. Level source i: pending[i] <= src[i] & mask[i] every cycle.
- Pending capture is independent of gie (interrupts arriving under CLI are kept).
- mode_we: pending bits of sources whose mode changes are cleared the same clock. mask_we clearing mask[i] clears pending[i].
- gie update: int_disable has priority over int_enable and reti in the same cycle.
- FSM:
  - IDLE: if gie=1 and pending!=0 -> REQ; active_id <= lowest set index; irq <= 1; irq_vector <= vector(active_id).
  - REQ: irq_ack -> SERVICE; irq<=0; in_service<=1; gie<=0; pending[active_id] cleared if edge mode. int_disable (no ack) -> IDLE, irq<=0, pending untouched. Ack and int_disable same cycle: ack wins, gie<=0.
  - SERVICE: reti -> IDLE; in_service<=0; gie<=1. int_enable inside service sets gie but does not nest (no new request until IDLE).
- Request is committed in REQ: pending/mask changes do not alter active_id or irq_vector.
- irq_ack outside REQ ignored; reti outside SERVICE only sets gie.
- Level source still high after reti re-requests (handler must clear the source).
- irq_vector returns to 0 on leaving REQ; active_id holds through SERVICE.

## Timing
- Edge on src sampled at clock k: pending visible after k, irq=1 after k+1 (if IDLE, gie=1).
- Ack at clock a: irq=0, in_service=1, gie=0 after a.
- reti at clock r: IDLE after r; next request earliest after r+1.
- Minimum spacing between successive irq assertions: ack, reti, +1 cycle.
- Higher-priority pending arriving during REQ is taken only after the current service completes.

## Test plan
- Reset, mask=4'b1111, SEI, pulse src[2] (edge) -> pending[2]=1 next cycle, irq=1 with irq_vector=8'h06, active_id=2 one cycle later; ack -> pending[2]=0, in_service=1, gie=0.
- src[3] and src[1] rise same cycle -> vector 8'h04 first; after reti, 8'h08 served next; irq one cycle after reti.
- Edge on src[0] with gie=0 -> no irq, pending[0]=1; SEI -> irq, vector 8'h02 two cycles later.
- src[1] level mode held high through reti -> second request for source 1 after reti; src low before reti -> no re-request.
- int_disable while irq=1, no ack -> irq drops, pending kept; SEI -> same vector re-requested. int_enable+int_disable same cycle -> gie=0.
- rst asserted in SERVICE with pending bits set -> all outputs zero next cycle, mask=0, mode all edge.
